// File: rtl/ext_arbiter_pkg.sv
// Shared types for the immediate-extension arbiter: extension mode encodings
// and the result-register FSM state.
package ext_arbiter_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_UPPER  = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ext_arbiter_ext_unit.sv
// Mode-selectable 16-to-32 bit immediate extender, purely combinational.
module ext_unit
  import ext_arbiter_pkg::*;
(
  input  logic [15:0] i_imm,
  input  logic [1:0]  i_mode,
  output logic [31:0] o_result
);

  // Branch offsets are word offsets, so they are scaled by 4 after sign extension.
  always_comb begin
    o_result = '0;
    case (ext_mode_t'(i_mode))
      EXT_SIGN:   o_result = {{16{i_imm[15]}}, i_imm};
      EXT_ZERO:   o_result = {16'h0000, i_imm};
      EXT_UPPER:  o_result = {i_imm, 16'h0000};
      EXT_BRANCH: o_result = {{14{i_imm[15]}}, i_imm, 2'b00};
      default:    o_result = '0;
    endcase
  end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester round-robin arbiter feeding a shared immediate extender into a
// single registered output beat with valid/ready handshaking.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_imm,
  input  logic [1:0]       req0_mode,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_imm,
  input  logic [1:0]       req1_mode,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag
);

  arb_state_t       r_state;
  arb_state_t       w_nextState;
  logic             r_prio;
  logic [31:0]      r_data;
  logic             r_src;
  logic [TAG_W-1:0] r_tag;

  logic             w_canGrant;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_anyGrant;
  logic [15:0]      w_extImm;
  logic [1:0]       w_extMode;
  logic [31:0]      w_extResult;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Gating with Reset keeps both readies low while reset is held, even though
  // the state register already reads EMPTY.
  always_comb begin
    w_nextState = r_state;
    w_canGrant  = Reset && ((r_state == ST_EMPTY) || out_ready);
    w_grant0    = w_canGrant && req0_valid && (!req1_valid || !r_prio);
    w_grant1    = w_canGrant && req1_valid && (!req0_valid || r_prio);
    w_anyGrant  = w_grant0 || w_grant1;
    case (r_state)
      ST_EMPTY: if (w_anyGrant) w_nextState = ST_FULL;
      ST_FULL:  if (out_ready && !w_anyGrant) w_nextState = ST_EMPTY;
      default:  w_nextState = ST_EMPTY;
    endcase
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_extImm  = w_grant1 ? req1_imm  : req0_imm;
  assign w_extMode = w_grant1 ? req1_mode : req0_mode;

  ext_unit u_ext (
    .i_imm    (w_extImm),
    .i_mode   (w_extMode),
    .o_result (w_extResult)
  );

  // Priority flips to whichever requester was not just served, even when only
  // one was asking.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_prio <= 1'b0;
      r_data <= '0;
      r_src  <= 1'b0;
      r_tag  <= '0;
    end else if (w_anyGrant) begin
      r_prio <= w_grant0;
      r_data <= w_extResult;
      r_src  <= w_grant1;
      r_tag  <= w_grant1 ? req1_tag : req0_tag;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: accepted requests push their expected beat,
// presented beats pop and compare.
module tb_ext_arbiter;

  localparam int TAG_W = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [15:0]      req0_imm = '0, req1_imm = '0;
  logic [1:0]       req0_mode = '0, req1_mode = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             out_src;
  logic [TAG_W-1:0] out_tag;

  typedef struct packed {
    logic [31:0]      data;
    logic             src;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t expQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  ext_arbiter #(.TAG_W(TAG_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_imm(req0_imm),
    .req0_mode(req0_mode), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_imm(req1_imm),
    .req1_mode(req1_mode), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_tag(out_tag)
  );

  always #5 Clk = ~Clk;

  task automatic waitCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic driveReq0(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                           input logic [TAG_W-1:0] tag);
    req0_valid = v; req0_imm = imm; req0_mode = mode; req0_tag = tag;
  endtask

  task automatic driveReq1(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                           input logic [TAG_W-1:0] tag);
    req1_valid = v; req1_imm = imm; req1_mode = mode; req1_tag = tag;
  endtask

  task automatic pushBeat(input logic [31:0] d, input logic s, input logic [TAG_W-1:0] t);
    beat_t b;
    b.data = d; b.src = s; b.tag = t;
    expQ.push_back(b);
  endtask

  task automatic popBeat(output beat_t b, output bit ok);
    if (expQ.size() == 0) begin
      b = '0; ok = 1'b0;
    end else begin
      b = expQ.pop_front(); ok = 1'b1;
    end
  endtask

  task automatic applyReset();
    Reset = 1'b0;
    #2;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    expQ.delete();
  endtask

  task automatic test_reset();
    driveReq0(1'b1, 16'h1234, 2'b01, 4'd1);
    driveReq1(1'b1, 16'h5678, 2'b01, 4'd2);
    out_ready = 1'b1;
    #3;
    testsRun++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
    end
    waitCycle();
    waitCycle();
    testsRun++;
    if ({out_valid, out_data, out_src, out_tag} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h src=%b tag=%h, want all zero",
               out_valid, out_data, out_src, out_tag);
    end
    testsRun++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready_after_edges: got %b, want 00", {req0_ready, req1_ready});
    end
    driveReq0(1'b0, '0, '0, '0);
    driveReq1(1'b0, '0, '0, '0);
    Reset = 1'b1;
    waitCycle();
  endtask

  task automatic test_single();
    beat_t e; bit ok;
    driveReq0(1'b1, 16'h8001, 2'b00, 4'd3);
    out_ready = 1'b1;
    #1;
    testsRun++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL single_ready: got %b, want 10", {req0_ready, req1_ready});
    end
    pushBeat(32'hFFFF8001, 1'b0, 4'd3);
    waitCycle();
    driveReq0(1'b0, '0, '0, '0);
    popBeat(e, ok);
    testsRun++;
    if (!ok || out_valid !== 1'b1 || {out_data, out_src, out_tag} !== e) begin
      testsFailed++;
      $display("[TB] FAIL single_beat: got v=%b data=%h src=%b tag=%h, want v=1 data=%h src=%b tag=%h",
               out_valid, out_data, out_src, out_tag, e.data, e.src, e.tag);
    end
    waitCycle();
  endtask

  task automatic test_mode_sweep();
    beat_t e; bit ok;
    logic [31:0] want [4];
    want[0] = 32'hFFFFFFFE; want[1] = 32'h0000FFFE;
    want[2] = 32'hFFFE0000; want[3] = 32'hFFFFFFF8;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      driveReq0(1'b1, 16'hFFFE, m[1:0], TAG_W'(m + 8));
      #1;
      testsRun++;
      if (req0_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL mode_ready_%0d: got %b, want 1", m, req0_ready);
      end
      pushBeat(want[m], 1'b0, TAG_W'(m + 8));
      waitCycle();
      popBeat(e, ok);
      testsRun++;
      if (!ok || out_valid !== 1'b1 || {out_data, out_src, out_tag} !== e) begin
        testsFailed++;
        $display("[TB] FAIL mode_%0d: got v=%b data=%h src=%b tag=%h, want v=1 data=%h src=%b tag=%h",
                 m, out_valid, out_data, out_src, out_tag, e.data, e.src, e.tag);
      end
    end
    driveReq0(1'b0, '0, '0, '0);
    waitCycle();
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL drain_to_empty: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    beat_t e; bit ok;
    applyReset();
    driveReq0(1'b1, 16'h0010, 2'b01, 4'd1);
    driveReq1(1'b1, 16'h0020, 2'b01, 4'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      testsRun++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        testsFailed++;
        $display("[TB] FAIL rr_grant_%0d: got %b, want %b", i, {req0_ready, req1_ready},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (i % 2 == 0) pushBeat(32'h00000010, 1'b0, 4'd1);
      else            pushBeat(32'h00000020, 1'b1, 4'd2);
      waitCycle();
      popBeat(e, ok);
      testsRun++;
      if (!ok || out_valid !== 1'b1 || {out_data, out_src, out_tag} !== e) begin
        testsFailed++;
        $display("[TB] FAIL rr_beat_%0d: got v=%b data=%h src=%b tag=%h, want v=1 data=%h src=%b tag=%h",
                 i, out_valid, out_data, out_src, out_tag, e.data, e.src, e.tag);
      end
    end
    driveReq0(1'b0, '0, '0, '0);
    driveReq1(1'b0, '0, '0, '0);
    waitCycle();
  endtask

  task automatic test_back_to_back();
    beat_t e; bit ok;
    driveReq0(1'b1, 16'h1111, 2'b01, 4'd5);
    out_ready = 1'b1;
    #1;
    pushBeat(32'h00001111, 1'b0, 4'd5);
    waitCycle();
    driveReq0(1'b0, '0, '0, '0);
    driveReq1(1'b1, 16'h2222, 2'b01, 4'd6);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      testsRun++;
      if (req1_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h00001111) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold_%0d: got ready1=%b v=%b data=%h, want ready1=0 v=1 data=00001111",
                 i, req1_ready, out_valid, out_data);
      end
      waitCycle();
    end
    out_ready = 1'b1;
    #1;
    testsRun++;
    if (req1_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_release_ready: got %b, want 1", req1_ready);
    end
    popBeat(e, ok);
    testsRun++;
    if (!ok || {out_data, out_src, out_tag} !== e) begin
      testsFailed++;
      $display("[TB] FAIL bp_held_beat: got data=%h src=%b tag=%h, want data=%h src=%b tag=%h",
               out_data, out_src, out_tag, e.data, e.src, e.tag);
    end
    pushBeat(32'h00002222, 1'b1, 4'd6);
    waitCycle();
    driveReq1(1'b0, '0, '0, '0);
    popBeat(e, ok);
    testsRun++;
    if (!ok || out_valid !== 1'b1 || {out_data, out_src, out_tag} !== e) begin
      testsFailed++;
      $display("[TB] FAIL bp_new_beat: got v=%b data=%h src=%b tag=%h, want v=1 data=%h src=%b tag=%h",
               out_valid, out_data, out_src, out_tag, e.data, e.src, e.tag);
    end
    waitCycle();
  endtask

  task automatic test_reset_while_full();
    beat_t e; bit ok;
    driveReq0(1'b1, 16'h1234, 2'b01, 4'd7);
    out_ready = 1'b1;
    #1;
    waitCycle();
    driveReq0(1'b1, 16'hAAAA, 2'b01, 4'd9);
    driveReq1(1'b1, 16'hBBBB, 2'b01, 4'd10);
    out_ready = 1'b0;
    #1;
    testsRun++;
    if (out_valid !== 1'b1 || out_data !== 32'h00001234) begin
      testsFailed++;
      $display("[TB] FAIL rwf_full: got v=%b data=%h, want v=1 data=00001234", out_valid, out_data);
    end
    #1;
    Reset = 1'b0;
    #1;
    testsRun++;
    if ({out_valid, out_data, out_src, out_tag} !== '0 || {req0_ready, req1_ready} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL rwf_async: got v=%b data=%h src=%b tag=%h rdy=%b, want all zero",
               out_valid, out_data, out_src, out_tag, {req0_ready, req1_ready});
    end
    expQ.delete();
    waitCycle();
    Reset = 1'b1;
    out_ready = 1'b1;
    #1;
    testsRun++;
    if (out_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL rwf_restart: got v=%b rdy=%b, want v=0 rdy=10",
               out_valid, {req0_ready, req1_ready});
    end
    pushBeat(32'h0000AAAA, 1'b0, 4'd9);
    waitCycle();
    driveReq0(1'b0, '0, '0, '0);
    driveReq1(1'b0, '0, '0, '0);
    popBeat(e, ok);
    testsRun++;
    if (!ok || out_valid !== 1'b1 || {out_data, out_src, out_tag} !== e) begin
      testsFailed++;
      $display("[TB] FAIL rwf_first_beat: got v=%b data=%h src=%b tag=%h, want v=1 data=%h src=%b tag=%h",
               out_valid, out_data, out_src, out_tag, e.data, e.src, e.tag);
    end
    waitCycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_mode_sweep();
    test_round_robin();
    test_back_to_back();
    test_reset_while_full();
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_empty: got %0d leftover beats, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
